mul_hilo_ctrl: RTL and testbench

Sequencer and HI/LO register file placed directly downstream of the shift-add multiplier. It decodes the funct field of issued instructions and launches the multiplier with a one-cycle `firstart` pulse. It waits a fixed number of cycles, then captures the 64-bit product into HI/LO and serves MFHI/MFLO reads. A read issued while a multiply is in flight is held in a one-entry pending slot and answered with the new product.

---
 rtl/mul_hilo_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mul_hilo_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_hilo_ctrl.sv
// HI/LO sequencer behind the shift-add multiplier: launches it, captures the product and serves reads.
// Optional MTHI/MTLO write support is compiled in when MUL_HILO_MT_EN is defined.
module mul_hilo_ctrl #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [5:0]  Signal,
  input  logic [31:0] dataA,
  input  logic [63:0] dataIn,
  output logic        firstart,
  output logic        busy,
  output logic        done,
  output logic [31:0] dataOut,
  output logic        outValid,
  output logic        drop
);

  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;

  localparam int              CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [31:0]      hi_reg, hi_next;
  logic [31:0]      lo_reg, lo_next;
  logic             pend_reg, pend_next;
  logic             pend_hi_reg, pend_hi_next;
  logic             firstart_reg, firstart_next;
  logic [31:0]      dataout_reg, dataout_next;
  logic             outvalid_reg, outvalid_next;
  logic             drop_reg, drop_next;

  logic is_multu;
  logic is_read;
  logic read_hi;
  logic is_idle;

  assign is_multu = valid && (Signal == FN_MULTU);
  assign is_read  = valid && ((Signal == FN_MFHI) || (Signal == FN_MFLO));
  assign read_hi  = (Signal == FN_MFHI);
  assign is_idle  = (state_reg == IDLE);

`ifdef MUL_HILO_MT_EN
  logic is_mthi;
  logic is_mtlo;
  assign is_mthi = valid && (Signal == FN_MTHI);
  assign is_mtlo = valid && (Signal == FN_MTLO);
`else
  logic unused_dataa;
  assign unused_dataa = ^{dataA, FN_MTHI, FN_MTLO};
`endif

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (is_multu) state_next = START;
      end
      START: begin
        state_next = RUN;
        count_next = '0;
      end
      RUN: begin
        if (count_reg == CNT_LAST) state_next = WRITE;
        else                       count_next = count_reg + 1'b1;
      end
      WRITE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- FSM outputs
  always_comb begin
    busy          = (state_reg != IDLE);
    done          = (state_reg == WRITE);
    firstart_next = (state_next == START);
  end

  // ---------------------------------------------------------------- HI/LO and read path
  always_comb begin
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    pend_next     = pend_reg;
    pend_hi_next  = pend_hi_reg;
    dataout_next  = dataout_reg;
    outvalid_next = 1'b0;
    drop_next     = 1'b0;

    if ((state_reg == RUN) && (count_reg == CNT_LAST)) begin
      hi_next = dataIn[63:32];
      lo_next = dataIn[31:0];
    end

    // HI/LO already hold the new product during WRITE, so the parked read is answered here
    if ((state_reg == WRITE) && pend_reg) begin
      dataout_next  = pend_hi_reg ? hi_reg : lo_reg;
      outvalid_next = 1'b1;
      pend_next     = 1'b0;
    end

    if (is_read) begin
      if (is_idle) begin
        dataout_next  = read_hi ? hi_reg : lo_reg;
        outvalid_next = 1'b1;
      end else if (pend_reg) begin
        drop_next = 1'b1;
      end else if (state_reg == WRITE) begin
        dataout_next  = read_hi ? hi_reg : lo_reg;
        outvalid_next = 1'b1;
      end else begin
        pend_next    = 1'b1;
        pend_hi_next = read_hi;
      end
    end

    if (is_multu && !is_idle) drop_next = 1'b1;

`ifdef MUL_HILO_MT_EN
    if (is_mthi || is_mtlo) begin
      if (is_idle) begin
        if (is_mthi) hi_next = dataA;
        else         lo_next = dataA;
      end else begin
        drop_next = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_reg       <= '0;
      lo_reg       <= '0;
      pend_reg     <= 1'b0;
      pend_hi_reg  <= 1'b0;
      firstart_reg <= 1'b0;
      dataout_reg  <= '0;
      outvalid_reg <= 1'b0;
      drop_reg     <= 1'b0;
    end else begin
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      pend_reg     <= pend_next;
      pend_hi_reg  <= pend_hi_next;
      firstart_reg <= firstart_next;
      dataout_reg  <= dataout_next;
      outvalid_reg <= outvalid_next;
      drop_reg     <= drop_next;
    end
  end

  assign firstart = firstart_reg;
  assign dataOut  = dataout_reg;
  assign outValid = outvalid_reg;
  assign drop     = drop_reg;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl with a behavioural shift-add multiplier stand-in.
module tb_mul_hilo_ctrl;

  localparam int MC = 32;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0;
  logic [5:0]  Signal = 6'h00;
  logic [31:0] dataA = 32'h0;
  logic [63:0] dataIn;
  logic        firstart, busy, done, outValid, drop;
  logic [31:0] dataOut;

  int total = 0;
  int passed = 0;

  // multiplier stand-in: latches operands on firstart, product appears after 32 falling-edge steps
  logic [31:0] opa = 32'h0, opb = 32'h0;
  logic [31:0] m_a, m_b;
  int          m_cnt;
  logic        m_run;

  mul_hilo_ctrl #(.MUL_CYCLES(MC)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid    (valid),
    .Signal   (Signal),
    .dataA    (dataA),
    .dataIn   (dataIn),
    .firstart (firstart),
    .busy     (busy),
    .done     (done),
    .dataOut  (dataOut),
    .outValid (outValid),
    .drop     (drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      m_run  <= 1'b0;
      m_cnt  <= 0;
      m_a    <= 32'h0;
      m_b    <= 32'h0;
      dataIn <= 64'h0;
    end else if (firstart) begin
      m_a    <= opa;
      m_b    <= opb;
      m_cnt  <= 0;
      m_run  <= 1'b1;
      dataIn <= 64'hBAD0_BAD0_BAD0_BAD0;
    end else if (m_run) begin
      if (m_cnt == 31) begin
        dataIn <= {32'h0, m_a} * {32'h0, m_b};
        m_run  <= 1'b0;
      end else begin
        dataIn <= 64'hBAD0_BAD0_0000_0000 | 64'(m_cnt);
      end
      m_cnt <= m_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a);
    valid  = 1'b1;
    Signal = f;
    dataA  = a;
    step();
    valid  = 1'b0;
    Signal = 6'h00;
    dataA  = 32'h0;
  endtask

  // n counts rising edges since the issuing edge; stops when done is seen or the budget runs out
  task automatic wait_done(input int start, output int n);
    n = start;
    while (!done && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    total++;
    if ({firstart, busy, done, outValid, drop} !== 5'b0) $display("FAIL reset_ctrl got=%b want=00000", {firstart, busy, done, outValid, drop});
    else passed++;
    total++;
    if (dataOut !== 32'h0) $display("FAIL reset_dataout got=%h want=00000000", dataOut);
    else passed++;
    reset = 1'b1;
    step();
    issue(FN_MFLO, 32'h0);
    total++;
    if (outValid !== 1'b1 || dataOut !== 32'h0) $display("FAIL reset_mflo got=%b/%h want=1/00000000", outValid, dataOut);
    else passed++;
    $display("reset: MFLO after reset -> %h", dataOut);
  endtask

  task automatic test_multu(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    opa = a;
    opb = b;
    issue(FN_MULTU, 32'h0);
    total++;
    if (firstart !== 1'b1 || busy !== 1'b1) $display("FAIL multu_firstart got=%b/%b want=1/1", firstart, busy);
    else passed++;
    step();
    total++;
    if (firstart !== 1'b0) $display("FAIL multu_firstart_pulse got=%b want=0", firstart);
    else passed++;
    wait_done(1, n);
    total++;
    if (n !== 33) $display("FAIL multu_done_latency got=%0d want=33", n);
    else passed++;
    step();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL multu_busy_clear got=%b/%b want=0/0", busy, done);
    else passed++;
    issue(FN_MFHI, 32'h0);
    total++;
    if (outValid !== 1'b1 || dataOut !== exp_hi) $display("FAIL multu_mfhi got=%b/%h want=1/%h", outValid, dataOut, exp_hi);
    else passed++;
    issue(FN_MFLO, 32'h0);
    total++;
    if (outValid !== 1'b1 || dataOut !== exp_lo) $display("FAIL multu_mflo got=%b/%h want=1/%h", outValid, dataOut, exp_lo);
    else passed++;
    step();
    total++;
    if (outValid !== 1'b0) $display("FAIL multu_outvalid_pulse got=%b want=0", outValid);
    else passed++;
    $display("multu %h*%h: done after %0d edges, lo=%h", a, b, n, exp_lo);
  endtask

  task automatic test_pending();
    int n;
    opa = 32'h0001_0000;
    opb = 32'h0001_0000;
    issue(FN_MULTU, 32'h0);
    repeat (4) step();
    issue(FN_MFHI, 32'h0);
    total++;
    if (outValid !== 1'b0 || drop !== 1'b0) $display("FAIL pend_hold got=%b/%b want=0/0", outValid, drop);
    else passed++;
    issue(FN_MFLO, 32'h0);
    total++;
    if (drop !== 1'b1 || outValid !== 1'b0) $display("FAIL pend_second_drop got=%b/%b want=1/0", drop, outValid);
    else passed++;
    step();
    total++;
    if (drop !== 1'b0) $display("FAIL pend_drop_pulse got=%b want=0", drop);
    else passed++;
    wait_done(7, n);
    total++;
    if (n !== 33 || outValid !== 1'b0) $display("FAIL pend_done got=%0d/%b want=33/0", n, outValid);
    else passed++;
    step();
    total++;
    if (outValid !== 1'b1 || dataOut !== 32'h0000_0001 || busy !== 1'b0) $display("FAIL pend_serve got=%b/%h/%b want=1/00000001/0", outValid, dataOut, busy);
    else passed++;
    step();
    total++;
    if (outValid !== 1'b0 || dataOut !== 32'h0000_0001) $display("FAIL pend_hold_value got=%b/%h want=0/00000001", outValid, dataOut);
    else passed++;
    issue(FN_MFLO, 32'h0);
    total++;
    if (outValid !== 1'b1 || dataOut !== 32'h0) $display("FAIL pend_lo got=%b/%h want=1/00000000", outValid, dataOut);
    else passed++;
    $display("pending: MFHI served with %h", 32'h1);
  endtask

  task automatic test_drop_multu();
    int n;
    opa = 32'd7;
    opb = 32'd9;
    issue(FN_MULTU, 32'h0);
    repeat (9) step();
    opa = 32'd100;
    opb = 32'd100;
    issue(FN_MULTU, 32'h0);
    total++;
    if (drop !== 1'b1 || firstart !== 1'b0 || busy !== 1'b1) $display("FAIL drop_run got=%b/%b/%b want=1/0/1", drop, firstart, busy);
    else passed++;
    wait_done(10, n);
    total++;
    if (n !== 33) $display("FAIL drop_done_latency got=%0d want=33", n);
    else passed++;
    issue(FN_MULTU, 32'h0);
    total++;
    if (drop !== 1'b1 || firstart !== 1'b0 || busy !== 1'b0) $display("FAIL drop_write got=%b/%b/%b want=1/0/0", drop, firstart, busy);
    else passed++;
    issue(FN_MFHI, 32'h0);
    total++;
    if (outValid !== 1'b1 || dataOut !== 32'h0) $display("FAIL drop_mfhi got=%b/%h want=1/00000000", outValid, dataOut);
    else passed++;
    issue(FN_MFLO, 32'h0);
    total++;
    if (outValid !== 1'b1 || dataOut !== 32'h0000_003F) $display("FAIL drop_mflo got=%b/%h want=1/0000003f", outValid, dataOut);
    else passed++;
    $display("drop: MULTU during RUN/WRITE discarded, lo=%h", dataOut);
  endtask

  task automatic test_back_to_back();
    int n;
    opa = 32'd2;
    opb = 32'd3;
    issue(FN_MULTU, 32'h0);
    step();
    step();
    issue(FN_MFLO, 32'h0);
    wait_done(3, n);
    step();
    total++;
    if (outValid !== 1'b1 || dataOut !== 32'h0000_0006 || busy !== 1'b0) $display("FAIL b2b_serve got=%b/%h/%b want=1/00000006/0", outValid, dataOut, busy);
    else passed++;
    opa = 32'd4;
    opb = 32'd5;
    issue(FN_MULTU, 32'h0);
    total++;
    if (firstart !== 1'b1 || drop !== 1'b0 || outValid !== 1'b0) $display("FAIL b2b_accept got=%b/%b/%b want=1/0/0", firstart, drop, outValid);
    else passed++;
    wait_done(0, n);
    total++;
    if (n !== 33) $display("FAIL b2b_done_latency got=%0d want=33", n);
    else passed++;
    step();
    issue(FN_MFLO, 32'h0);
    total++;
    if (outValid !== 1'b1 || dataOut !== 32'h0000_0014) $display("FAIL b2b_mflo got=%b/%h want=1/00000014", outValid, dataOut);
    else passed++;
    $display("back_to_back: second product lo=%h", dataOut);
  endtask

  task automatic test_mt();
`ifdef MUL_HILO_MT_EN
    int n;
    issue(FN_MTLO, 32'hDEAD_BEEF);
    total++;
    if (drop !== 1'b0 || outValid !== 1'b0) $display("FAIL mt_mtlo got=%b/%b want=0/0", drop, outValid);
    else passed++;
    issue(FN_MFLO, 32'h0);
    total++;
    if (outValid !== 1'b1 || dataOut !== 32'hDEAD_BEEF) $display("FAIL mt_mflo got=%b/%h want=1/deadbeef", outValid, dataOut);
    else passed++;
    issue(FN_MTHI, 32'hCAFE_F00D);
    issue(FN_MFHI, 32'h0);
    total++;
    if (outValid !== 1'b1 || dataOut !== 32'hCAFE_F00D) $display("FAIL mt_mfhi got=%b/%h want=1/cafef00d", outValid, dataOut);
    else passed++;
    opa = 32'd1;
    opb = 32'd1;
    issue(FN_MULTU, 32'h0);
    step();
    issue(FN_MTHI, 32'h0000_0123);
    total++;
    if (drop !== 1'b1) $display("FAIL mt_busy_drop got=%b want=1", drop);
    else passed++;
    wait_done(2, n);
    step();
    issue(FN_MFHI, 32'h0);
    total++;
    if (outValid !== 1'b1 || dataOut !== 32'h0) $display("FAIL mt_after_multu got=%b/%h want=1/00000000", outValid, dataOut);
    else passed++;
    $display("mt: enabled, MTLO/MTHI written");
`else
    issue(FN_MTLO, 32'hDEAD_BEEF);
    total++;
    if (drop !== 1'b0 || outValid !== 1'b0) $display("FAIL mt_ignored got=%b/%b want=0/0", drop, outValid);
    else passed++;
    issue(FN_MFLO, 32'h0);
    total++;
    if (outValid !== 1'b1 || dataOut !== 32'h0000_0014) $display("FAIL mt_lo_unchanged got=%b/%h want=1/00000014", outValid, dataOut);
    else passed++;
    issue(FN_MTHI, 32'hCAFE_F00D);
    issue(FN_MFHI, 32'h0);
    total++;
    if (outValid !== 1'b1 || dataOut !== 32'h0) $display("FAIL mt_hi_unchanged got=%b/%h want=1/00000000", outValid, dataOut);
    else passed++;
    $display("mt: disabled, HI/LO unchanged");
`endif
    issue(6'h2A, 32'h0);
    total++;
    if ({drop, outValid, busy, firstart} !== 4'b0) $display("FAIL unknown_funct got=%b want=0000", {drop, outValid, busy, firstart});
    else passed++;
  endtask

  task automatic test_abort();
    int pulses;
    opa = 32'h0001_2345;
    opb = 32'h0000_0010;
    issue(FN_MULTU, 32'h0);
    repeat (10) step();
    issue(FN_MFHI, 32'h0);
    step();
    #2 reset = 1'b0;
    #1;
    total++;
    if ({busy, firstart, done, outValid} !== 4'b0) $display("FAIL abort_run got=%b want=0000", {busy, firstart, done, outValid});
    else passed++;
    #2 reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (outValid || busy) pulses++;
    end
    total++;
    if (pulses !== 0) $display("FAIL abort_no_activity got=%0d want=0", pulses);
    else passed++;
    issue(FN_MFLO, 32'h0);
    total++;
    if (outValid !== 1'b1 || dataOut !== 32'h0) $display("FAIL abort_mflo got=%b/%h want=1/00000000", outValid, dataOut);
    else passed++;
    issue(FN_MULTU, 32'h0);
    #2 reset = 1'b0;
    #1;
    total++;
    if (firstart !== 1'b0 || busy !== 1'b0) $display("FAIL abort_start got=%b/%b want=0/0", firstart, busy);
    else passed++;
    #2 reset = 1'b1;
    step();
    total++;
    if (busy !== 1'b0 || firstart !== 1'b0) $display("FAIL abort_stays_idle got=%b/%b want=0/0", busy, firstart);
    else passed++;
    $display("abort: reset mid-RUN and in START cleared state");
  endtask

  initial begin
    test_reset();
    test_multu(32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F);
    test_multu(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    test_pending();
    test_drop_multu();
    test_back_to_back();
    test_mt();
    test_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
